alu_seq: RTL and testbench

Execute sequencer for the 16-bit datapath: accepts one decoded 16-bit instruction per valid/ready handshake, reads two operands from an internal 8×16 register file, drives the combinational ALU's operand/select/enable inputs, and captures the ALU result and carry back into the register file and flags. It is the initiator side of the ALU interface, sitting between instruction fetch/decode and the ALU.

---
 rtl/alu_seq.sv | 144 ++++++++++++++
 tb/tb_alu_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - execute sequencer driving a combinational ALU from an 8x16 register file
module alu_seq #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_select,
    output logic              alu_enable,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    output logic              done,
    output logic              err,
    output logic              flag_z,
    output logic              flag_c,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [2:0]          alu_sel_q, alu_sel_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                flag_z_q, flag_z_d;
    logic                flag_c_q, flag_c_d;
    logic [DATA_W-1:0]   rf_q [NREGS];

    logic                wr_en;
    logic [DATA_W-1:0]   wr_data;

    // Instruction bit 0 is the MSB, so field bit i lives at vector index DATA_W-1-i.
    logic [2:0] op, rd, ra, rb;
    logic [7:0] imm8;
    logic       is_alu, is_ldi;

    assign op     = instr_q[15:13];
    assign rd     = instr_q[12:10];
    assign ra     = instr_q[9:7];
    assign rb     = instr_q[6:4];
    assign imm8   = instr_q[7:0];
    assign is_alu = ~op[2];
    assign is_ldi = (op == 3'b100);

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        flag_z_d  = flag_z_q;
        flag_c_d  = flag_c_q;
        wr_en     = 1'b0;
        wr_data   = '0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    instr_d = in_instr;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (is_alu) begin
                    alu_a_d   = rf_q[ra];
                    alu_b_d   = rf_q[rb];
                    alu_sel_d = op;
                end
                state_d = S_EXEC;
            end
            S_EXEC: state_d = S_WB;
            S_WB: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (is_alu) begin
                    wr_en    = 1'b1;
                    wr_data  = alu_out;
                    flag_z_d = (alu_out == '0);
                    if (op == 3'b000) flag_c_d = alu_carry;
                end else if (is_ldi) begin
                    wr_en    = 1'b1;
                    wr_data  = {8'h00, imm8};
                    flag_z_d = (imm8 == 8'h00);
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            done_q    <= done_d;
            err_q     <= err_d;
            flag_z_q  <= flag_z_d;
            flag_c_q  <= flag_c_d;
            if (wr_en) rf_q[rd] <= wr_data;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_select = alu_sel_q;
    assign alu_enable = is_alu && ((state_q == S_EXEC) || (state_q == S_WB));
    assign done       = done_q;
    assign err        = err_q;
    assign flag_z     = flag_z_q;
    assign flag_c     = flag_c_q;
    assign dbg_data   = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq with a behavioural ALU and reference model
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_select;
    logic        alu_enable, alu_carry;
    logic        done, err, flag_z, flag_c;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
        .alu_enable(alu_enable), .alu_out(alu_out), .alu_carry(alu_carry),
        .done(done), .err(err), .flag_z(flag_z), .flag_c(flag_c),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Environment ALU; SUB drives its borrow on alu_carry so a DUT that wrongly
    // takes carry from SUB is exposed.
    always_comb begin
        case (alu_select)
            3'b000:  {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001:  {alu_carry, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
            3'b010:  {alu_carry, alu_out} = {1'b0, alu_a ^ alu_b};
            3'b011:  {alu_carry, alu_out} = {1'b0, alu_a & alu_b};
            default: {alu_carry, alu_out} = 17'h0;
        endcase
    end

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] val;
        logic        z, c, e, is_alu;
        logic [15:0] a, b;
        logic [2:0]  sel;
        time         t;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_regs [8];
    logic        m_z, m_c;
    logic [15:0] m_a, m_b;
    logic [2:0]  m_sel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_z = 0; m_c = 0; m_a = 0; m_b = 0; m_sel = 0;
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input logic [7:0] imm, input bit hold);
        exp_t        e;
        logic [16:0] wide;
        int          n;
        in_instr = (op == 3'b100) ? {op, rd, 2'b00, imm} : {op, rd, ra, rb, 4'h0};
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        e.rd = rd; e.e = 0; e.is_alu = (op < 3'd4); e.t = $time;
        if (op < 3'd4) begin
            m_a = m_regs[ra]; m_b = m_regs[rb]; m_sel = op;
            case (op)
                3'd0: wide = m_a + m_b;
                3'd1: wide = {1'b0, m_a - m_b};
                3'd2: wide = {1'b0, m_a ^ m_b};
                default: wide = {1'b0, m_a & m_b};
            endcase
            m_regs[rd] = wide[15:0];
            m_z = (wide[15:0] == 16'h0);
            if (op == 3'd0) m_c = wide[16];
        end else if (op == 3'd4) begin
            m_regs[rd] = {8'h00, imm};
            m_z = (imm == 8'h00);
        end else begin
            e.e = 1;
        end
        e.val = m_regs[rd]; e.z = m_z; e.c = m_c; e.a = m_a; e.b = m_b; e.sel = m_sel;
        sb.push_back(e);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = hold;
            in_instr = 16'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    int en_cnt = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1) begin
                en_cnt = 0;
            end else begin
                if (alu_enable) en_cnt++;
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("err", err, e.e);
                        chk("flag_z", flag_z, e.z);
                        chk("flag_c", flag_c, e.c);
                        chk("latency", 32'($time - e.t), 32'd35);
                        chk("enable_cycles", en_cnt, e.is_alu ? 2 : 0);
                        chk("alu_a", alu_a, e.a);
                        chk("alu_b", alu_b, e.b);
                        chk("alu_select", alu_select, e.sel);
                        chk("in_ready_at_done", in_ready, 1'b1);
                        dbg_addr = e.rd;
                        #1;
                        chk("reg_rd", dbg_data, e.val);
                    end
                    en_cnt = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0; in_valid = 0; in_instr = 0; dbg_addr = 0;
        model_reset();
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_done", done, 0);   chk("rst_err", err, 0);
        chk("rst_flag_z", flag_z, 0); chk("rst_flag_c", flag_c, 0);
        chk("rst_alu_a", alu_a, 0); chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_select", alu_select, 0); chk("rst_alu_enable", alu_enable, 0);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1 chk("rst_dbg", dbg_data, 0);
        end
        reset_n = 1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        issue(3'd4, 3'd1, 0, 0, 8'h05, 0);
        issue(3'd4, 3'd2, 0, 0, 8'h03, 0);
        issue(3'd0, 3'd3, 3'd1, 3'd2, 0, 0);
        issue(3'd4, 3'd1, 0, 0, 8'hFF, 0);
        issue(3'd4, 3'd4, 0, 0, 8'h80, 0);
        for (int i = 0; i < 8; i++) issue(3'd0, 3'd4, 3'd4, 3'd4, 0, 0);
        issue(3'd0, 3'd4, 3'd4, 3'd4, 0, 0);
        issue(3'd2, 3'd5, 3'd1, 3'd1, 0, 0);
        issue(3'd4, 3'd1, 0, 0, 8'h01, 0);
        issue(3'd1, 3'd6, 3'd0, 3'd1, 0, 0);
        issue(3'd4, 3'd2, 0, 0, 8'hF0, 0);
        issue(3'd4, 3'd7, 0, 0, 8'h3C, 0);
        issue(3'd3, 3'd5, 3'd2, 3'd7, 0, 0);
        issue(3'd6, 3'd2, 3'd1, 3'd1, 0, 1);

        // Reset while ADD r3 is in EXEC: the instruction must vanish.
        in_instr = {3'd0, 3'd3, 3'd1, 3'd2, 4'h0};
        in_valid = 1;
        @(posedge clk);
        @(negedge clk); in_valid = 0;
        @(negedge clk); reset_n = 0;
        @(negedge clk); @(negedge clk);
        sb.delete();
        model_reset();
        reset_n = 1;
        @(negedge clk);
        dbg_addr = 3'd3;
        #1 chk("abort_r3", dbg_data, 0);
        chk("abort_flag_c", flag_c, 0);
        chk("abort_in_ready", in_ready, 1);
        @(negedge clk);

        issue(3'd4, 3'd1, 0, 0, 8'h00, 0);
        issue(3'd4, 3'd3, 0, 0, 8'h07, 0);
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom),
                  8'($urandom), ($urandom_range(0, 3) == 0));
        end

        repeat (6) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
